// File: rtl/data_ram_resp.sv
// Data RAM with a two-entry posted-write buffer: stores are queued and drained
// into the array on cycles without a load, loads forward from pending stores per byte.
module data_ram_resp #(
    parameter int ADDR_W   = 10,
    parameter int WB_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stallreq_o,
    output logic        wb_empty_o
);

    localparam logic [1:0] WB_FULL = 2'(WB_DEPTH);

    logic [31:0]       mem_q [2**ADDR_W];

    // Entry 0 is always the oldest; a pop shifts entry 1 down.
    logic [ADDR_W-1:0] wb_idx_q  [2];
    logic [3:0]        wb_sel_q  [2];
    logic [31:0]       wb_data_q [2];
    logic [1:0]        count_q, count_d;

    logic [ADDR_W-1:0] idx;
    logic              is_load, is_store, stall, push, pop, wr_pos;
    logic [31:0]       fwd_data;
    logic              unused_addr_bits;

    assign idx              = addr_i[ADDR_W+1:2];
    assign unused_addr_bits = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};

    assign is_load  = rst & ce_i & ~we_i;
    assign is_store = rst & ce_i & we_i;
    assign stall    = is_store & (count_q == WB_FULL);
    assign push     = is_store & ~stall;
    assign pop      = rst & (count_q != 2'd0) & ~is_load;
    assign wr_pos   = (count_q == 2'd1) & ~pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // Younger entry is applied last so it wins in overlapping lanes.
    always_comb begin
        fwd_data = mem_q[idx];
        for (int lane = 0; lane < 4; lane++) begin
            if ((count_q != 2'd0) && (wb_idx_q[0] == idx) && wb_sel_q[0][lane]) begin
                fwd_data[lane*8 +: 8] = wb_data_q[0][lane*8 +: 8];
            end
            if ((count_q == 2'd2) && (wb_idx_q[1] == idx) && wb_sel_q[1][lane]) begin
                fwd_data[lane*8 +: 8] = wb_data_q[1][lane*8 +: 8];
            end
        end
    end

    assign data_o     = is_load ? fwd_data : 32'h0;
    assign stallreq_o = stall;
    assign wb_empty_o = (count_q == 2'd0) | ~rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
            if (pop && (count_q == 2'd2)) begin
                wb_idx_q[0]  <= wb_idx_q[1];
                wb_sel_q[0]  <= wb_sel_q[1];
                wb_data_q[0] <= wb_data_q[1];
            end
            if (push) begin
                wb_idx_q[wr_pos]  <= idx;
                wb_sel_q[wr_pos]  <= sel_i;
                wb_data_q[wr_pos] <= data_i;
            end
        end
    end

    // The array itself is never reset; only drains write it.
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (wb_sel_q[0][lane]) begin
                    mem_q[wb_idx_q[0]][lane*8 +: 8] <= wb_data_q[0][lane*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// Randomized bench for data_ram_resp against a queue-based model of the
// posted-write buffer and a word array.
module tb_data_ram_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce, we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] din;
    logic [31:0] dout;
    logic        stall_o, empty_o;

    data_ram_resp #(.ADDR_W(10), .WB_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce),
        .we_i       (we),
        .addr_i     (addr),
        .sel_i      (sel),
        .data_i     (din),
        .data_o     (dout),
        .stallreq_o (stall_o),
        .wb_empty_o (empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  idx;
        logic [3:0]  sel;
        logic [31:0] data;
    } ent_t;

    logic [31:0] mem_m [1024];
    ent_t        q [$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_data, obs_data;
    logic        exp_stall, obs_stall, exp_empty, obs_empty;

    function automatic logic [31:0] model_read(input logic [9:0] ix);
        logic [31:0] res;
        res = mem_m[ix];
        foreach (q[i]) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (q[i].idx == ix && q[i].sel[lane]) res[lane*8 +: 8] = q[i].data[lane*8 +: 8];
            end
        end
        return res;
    endfunction

    task automatic step(input logic r, input logic c, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] d);
        logic       ld, st;
        logic [9:0] ix;
        ent_t       e;
        @(negedge clk);
        rst = r; ce = c; we = w; addr = a; sel = s; din = d;
        #1;
        ix = a[11:2];
        ld = r && c && !w;
        st = r && c && w;
        exp_data  = ld ? model_read(ix) : 32'h0;
        exp_stall = st && (q.size() == 2);
        exp_empty = !r || (q.size() == 0);
        obs_data  = dout;
        obs_stall = stall_o;
        obs_empty = empty_o;
        @(posedge clk);
        if (!r) begin
            q.delete();
        end else begin
            if (!ld && q.size() > 0) begin
                e = q.pop_front();
                for (int lane = 0; lane < 4; lane++)
                    if (e.sel[lane]) mem_m[e.idx][lane*8 +: 8] = e.data[lane*8 +: 8];
            end
            if (st && !exp_stall) q.push_back('{ix, s, d});
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, $urandom, $urandom, $urandom);
    endtask

    task automatic load(input logic [31:0] a);
        step(1'b1, 1'b1, 1'b0, a, 4'($urandom), $urandom);
    endtask

    task automatic store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        int tries = 0;
        step(1'b1, 1'b1, 1'b1, a, s, d);
        while (obs_stall && tries < 4) begin
            tries++;
            step(1'b1, 1'b1, 1'b1, a, s, d);
        end
        if (obs_stall) begin
            n_cmp++; n_bad++;
            $display("FAIL store_accept: still stalled after %0d retries at addr %h", tries, a);
        end
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        n_cmp++;
        if (obs_data !== 32'h0 || obs_empty !== 1'b1 || obs_stall !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got data=%h empty=%b stall=%b want 0/1/0", obs_data, obs_empty, obs_stall);
        end
        step(1'b0, 1'b1, 1'b1, 32'h100, 4'hF, 32'h1234);
        n_cmp++;
        if (obs_stall !== 1'b0 || obs_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_store: got stall=%b empty=%b want 0/1", obs_stall, obs_empty);
        end
        idle();
        n_cmp++;
        if (obs_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_no_push: got empty=%b want 1", obs_empty);
        end
    endtask

    task automatic test_init();
        int guard = 0;
        for (int i = 0; i < 1024; i++) store({20'($urandom), 10'(i), 2'($urandom)}, 4'hF, $urandom);
        idle();
        while (!obs_empty && guard < 8) begin
            guard++;
            idle();
        end
        n_cmp++;
        if (obs_empty !== exp_empty || obs_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL init_drain: got empty=%b want 1", obs_empty);
        end
    endtask

    task automatic test_forward();
        store(32'h100, 4'hF, 32'hDEADBEEF);
        load(32'h100);
        n_cmp++;
        if (obs_data !== 32'hDEADBEEF || obs_data !== exp_data) begin
            n_bad++;
            $display("FAIL fwd_full: got %h want DEADBEEF", obs_data);
        end
        n_cmp++;
        if (obs_empty !== 1'b0) begin
            n_bad++;
            $display("FAIL fwd_empty: got %b want 0", obs_empty);
        end
    endtask

    task automatic test_partial();
        store(32'h40, 4'hF, 32'h11223344);
        idle(); idle();
        store(32'h40, 4'b0100, 32'hAAAAAAAA);
        load(32'h40);
        n_cmp++;
        if (obs_data !== 32'h11AA3344 || obs_data !== exp_data) begin
            n_bad++;
            $display("FAIL partial_fwd: got %h want 11AA3344", obs_data);
        end
        idle(); idle();
        load(32'h40);
        n_cmp++;
        if (obs_data !== 32'h11AA3344 || obs_empty !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_drained: got %h empty=%b want 11AA3344 empty=1", obs_data, obs_empty);
        end
    endtask

    task automatic test_back_to_back();
        store(32'h300, 4'hF, 32'hA0A0A0A0);
        load(32'h304);
        store(32'h304, 4'hF, 32'hB1B1B1B1);
        load(32'h308);
        step(1'b1, 1'b1, 1'b1, 32'h308, 4'hF, 32'hC2C2C2C2);
        n_cmp++;
        if (obs_stall !== exp_stall) begin
            n_bad++;
            $display("FAIL b2b_stall: got %b want %b", obs_stall, exp_stall);
        end
        if (obs_stall) store(32'h308, 4'hF, 32'hC2C2C2C2);
        idle(); idle();
        for (int i = 0; i < 3; i++) begin
            load(32'h300 + 32'(i * 4));
            n_cmp++;
            if (obs_data !== exp_data) begin
                n_bad++;
                $display("FAIL b2b_readback%0d: got %h want %h", i, obs_data, exp_data);
            end
        end
    endtask

    task automatic test_same_word();
        store(32'h80, 4'b1100, 32'h12340000);
        store(32'h80, 4'b0110, 32'h00567800);
        load(32'h80);
        n_cmp++;
        if (obs_data[31:8] !== 24'h125678 || obs_data !== exp_data) begin
            n_bad++;
            $display("FAIL same_word_pending: got %h want %h", obs_data, exp_data);
        end
        idle(); idle();
        load(32'h80);
        n_cmp++;
        if (obs_data[31:8] !== 24'h125678 || obs_data !== exp_data) begin
            n_bad++;
            $display("FAIL same_word_drained: got %h want %h", obs_data, exp_data);
        end
        store(32'h80, 4'b0000, 32'hFFFFFFFF);
        idle(); idle();
        load(32'h80);
        n_cmp++;
        if (obs_data !== exp_data) begin
            n_bad++;
            $display("FAIL zero_sel: got %h want %h", obs_data, exp_data);
        end
    endtask

    task automatic test_reset_pending();
        store(32'h200, 4'hF, 32'h55555555);
        store(32'h204, 4'hF, 32'h66666666);
        step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        load(32'h204);
        n_cmp++;
        if (obs_empty !== 1'b1 || obs_data !== exp_data) begin
            n_bad++;
            $display("FAIL reset_discard: got data=%h empty=%b want %h empty=1", obs_data, obs_empty, exp_data);
        end
    endtask

    task automatic test_alias();
        store(32'h0004, 4'hF, 32'hCAFEF00D);
        idle(); idle();
        load(32'h1004);
        n_cmp++;
        if (obs_data !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL alias: got %h want CAFEF00D", obs_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            logic r, c, w;
            logic [31:0] a;
            r = ($urandom_range(0, 49) != 0);
            c = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1);
            a = ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 7)) << 2);
            step(r, c, w, a, 4'($urandom), $urandom);
            n_cmp++;
            if (obs_data !== exp_data || obs_stall !== exp_stall || obs_empty !== exp_empty) begin
                n_bad++;
                $display("FAIL rand%0d: got data=%h stall=%b empty=%b want %h/%b/%b",
                         i, obs_data, obs_stall, obs_empty, exp_data, exp_stall, exp_empty);
            end
        end
    endtask

    initial begin
        rst = 1'b0; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; din = '0;
        test_reset();
        test_init();
        test_forward();
        test_partial();
        test_back_to_back();
        test_same_word();
        test_reset_pending();
        test_alias();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
